// File: rtl/sdes_round_ctrl.sv
// Iterative S-DES Feistel round controller sequencing one combinational f_function.
// Optional abort input enabled by defining SDES_CTRL_ABORT_EN.

module f_function (
    input  logic [3:0] r,
    input  logic [7:0] k,
    output logic [3:0] f
);
    logic [7:0] x;
    logic [1:0] s0o;
    logic [1:0] s1o;

    function automatic logic [1:0] sbox0(input logic [3:0] idx);
        case (idx)
            4'd0:  return 2'd1;  4'd1:  return 2'd0;  4'd2:  return 2'd3;  4'd3:  return 2'd2;
            4'd4:  return 2'd3;  4'd5:  return 2'd2;  4'd6:  return 2'd1;  4'd7:  return 2'd0;
            4'd8:  return 2'd0;  4'd9:  return 2'd2;  4'd10: return 2'd1;  4'd11: return 2'd3;
            4'd12: return 2'd3;  4'd13: return 2'd1;  4'd14: return 2'd3;  default: return 2'd2;
        endcase
    endfunction

    function automatic logic [1:0] sbox1(input logic [3:0] idx);
        case (idx)
            4'd0:  return 2'd0;  4'd1:  return 2'd1;  4'd2:  return 2'd2;  4'd3:  return 2'd3;
            4'd4:  return 2'd2;  4'd5:  return 2'd0;  4'd6:  return 2'd1;  4'd7:  return 2'd3;
            4'd8:  return 2'd3;  4'd9:  return 2'd0;  4'd10: return 2'd1;  4'd11: return 2'd0;
            4'd12: return 2'd2;  4'd13: return 2'd1;  4'd14: return 2'd0;  default: return 2'd3;
        endcase
    endfunction

    // Expansion/permutation 4-1-2-3-2-3-4-1 mixed with the round key, then S-boxes and P4 (2-4-3-1).
    always_comb begin
        x   = {r[0], r[3], r[2], r[1], r[2], r[1], r[0], r[3]} ^ k;
        s0o = sbox0({x[7], x[4], x[6], x[5]});
        s1o = sbox1({x[3], x[0], x[2], x[1]});
        f   = {s0o[0], s1o[0], s1o[1], s0o[1]};
    end
endmodule

module sdes_round_ctrl #(
    parameter int NUM_ROUNDS = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] din,
    input  logic [7:0] key,
    input  logic       decrypt,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] dout,
    output logic       busy
`ifdef SDES_CTRL_ABORT_EN
    ,
    input  logic       abort
`endif
);
    typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} state_t;

    localparam logic [2:0] LAST = 3'(NUM_ROUNDS - 1);

    state_t     state, state_nxt;
    logic [2:0] rc;
    logic [3:0] l, r;
    logic [7:0] kreg;
    logic       dreg;
    logic [2:0] ridx;
    logic [7:0] rkey;
    logic [3:0] fo;
    logic       abort_req;

`ifdef SDES_CTRL_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    function automatic logic [7:0] rotl8(input logic [7:0] v, input logic [2:0] n);
        logic [15:0] d;
        d = {v, v} << n;
        return d[15:8];
    endfunction

    // Decryption walks the same rotated-key schedule backwards.
    assign ridx = dreg ? (LAST - rc) : rc;
    assign rkey = rotl8(kreg, ridx);

    f_function u_f (
        .r (r),
        .k (rkey),
        .f (fo)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (in_valid) state_nxt = S_ROUND;
            S_ROUND: begin
                if (abort_req)       state_nxt = S_IDLE;
                else if (rc == LAST) state_nxt = S_DONE;
            end
            S_DONE:  if (abort_req || out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            rc    <= 3'd0;
            l     <= 4'd0;
            r     <= 4'd0;
            kreg  <= 8'd0;
            dreg  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && in_valid) begin
                l    <= din[7:4];
                r    <= din[3:0];
                kreg <= key;
                dreg <= decrypt;
                rc   <= 3'd0;
            end else if (state == S_ROUND) begin
                l  <= r;
                r  <= l ^ fo;
                rc <= rc + 3'd1;
            end
        end
    end

    // Outputs decode registered state only; the final swap is just the {R,L} ordering.
    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);
    assign dout      = {r, l};
endmodule
